player_life_tracker: RTL

Tracks hit points for both players and drives the per-player dying flags consumed by the LED flasher stage. Takes single-cycle hit pulses from the game/collision logic on the 100 MHz system clock, applies a post-hit invulnerability window, and holds `p1_dying` / `p2_dying` high for a fixed dying window once a player's HP reaches zero. Reports game-over and the winner to the top-level game controller.

---
 rtl/life_pkg.sv | 30 +++
 rtl/player_life_fsm.sv | 103 ++++++++++
 rtl/player_life_tracker.sv | 91 +++++++++
 3 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared types and widths for the player life tracker.
//   life_state_e : per-player FSM state encoding
//   winner_e     : winner report codes (valid while game_over is high)
//   HP_W, CNT_W  : HP register width and 10 Hz tick counter width
//   hp_dec       : saturating HP decrement
package life_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DYING  = 2'd2,
    OUT    = 2'd3
  } life_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  localparam int HP_W  = 3;
  localparam int CNT_W = 8;

  // HP is unsigned; never wraps below zero.
  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? '0 : hp - HP_W'(1);
  endfunction

endpackage

// File: rtl/player_life_fsm.sv
// player_life_fsm: HP register, tick counter and life FSM for one player.
// Ports:
//   clk, rst      : system clock, async active-high reset
//   tick10        : 10 Hz one-cycle enable
//   game_start    : restart pulse, overrides hit and tick
//   hit           : one-cycle hit pulse
//   hp            : current HP (registered)
//   dying         : high for the whole dying window (registered)
//   is_out        : player has finished dying
module player_life_fsm
  import life_pkg::*;
#(
  parameter int MAX_HP       = 3,
  parameter int INVULN_TICKS = 10,
  parameter int DYING_TICKS  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick10,
  input  logic            game_start,
  input  logic            hit,
  output logic [HP_W-1:0] hp,
  output logic            dying,
  output logic            is_out
);

  life_state_e      state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dying_q, dying_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [HP_W-1:0]  hp_hit;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign hp_hit  = hp_dec(hp_q);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    if (game_start) begin
      state_d = ALIVE;
      hp_d    = HP_W'(MAX_HP);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          // A tick coinciding with the hit is dropped: the new window starts at 0.
          if (hit) begin
            hp_d    = hp_hit;
            cnt_d   = '0;
            state_d = (hp_hit == '0) ? DYING : INVULN;
          end
        end
        INVULN: begin
          if (tick10) begin
            if (cnt_inc == CNT_W'(INVULN_TICKS)) begin
              state_d = ALIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        DYING: begin
          if (tick10) begin
            if (cnt_inc == CNT_W'(DYING_TICKS)) begin
              state_d = OUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        OUT: begin
          hp_d = '0;
        end
        default: state_d = ALIVE;
      endcase
    end
    // Registered so the flasher sees a clean level from the next edge.
    dying_d = (state_d == DYING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALIVE;
      hp_q    <= HP_W'(MAX_HP);
      cnt_q   <= '0;
      dying_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      dying_q <= dying_d;
    end
  end

  assign hp     = hp_q;
  assign dying  = dying_q;
  assign is_out = (state_q == OUT);

endmodule

// File: rtl/player_life_tracker.sv
// player_life_tracker: two-player HP / dying tracker with game-over report.
// Ports:
//   clk, rst             : 100 MHz clock, async active-high reset
//   tick10               : 10 Hz one-cycle enable
//   game_start           : restarts both players, clears game over
//   p1_hit, p2_hit       : one-cycle hit pulses
//   p1_hp, p2_hp         : current HP
//   p1_dying, p2_dying   : dying window levels for the LED flasher
//   game_over            : set the cycle after any player is out
//   winner               : 00 none, 01 P1, 10 P2, 11 draw
module player_life_tracker
  import life_pkg::*;
#(
  parameter int MAX_HP       = 3,
  parameter int INVULN_TICKS = 10,
  parameter int DYING_TICKS  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick10,
  input  logic       game_start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic [2:0] p1_hp,
  output logic [2:0] p2_hp,
  output logic       p1_dying,
  output logic       p2_dying,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int NUM_PLAYERS = 2;

  logic [NUM_PLAYERS-1:0]           hit;
  logic [NUM_PLAYERS-1:0][HP_W-1:0] hp;
  logic [NUM_PLAYERS-1:0]           dying;
  logic [NUM_PLAYERS-1:0]           is_out;

  assign hit = {p2_hit, p1_hit};

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    player_life_fsm #(
      .MAX_HP       (MAX_HP),
      .INVULN_TICKS (INVULN_TICKS),
      .DYING_TICKS  (DYING_TICKS)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .tick10     (tick10),
      .game_start (game_start),
      .hit        (hit[p]),
      .hp         (hp[p]),
      .dying      (dying[p]),
      .is_out     (is_out[p])
    );
  end

  logic    game_over_q, game_over_d;
  winner_e winner_q, winner_d;

  always_comb begin
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (game_start) begin
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
    end else if (!game_over_q && (is_out != '0)) begin
      // Winner is the player still standing: P2 out -> P1 (01), P1 out -> P2 (10).
      game_over_d = 1'b1;
      winner_d    = winner_e'({is_out[0], is_out[1]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign p1_hp     = hp[0];
  assign p2_hp     = hp[1];
  assign p1_dying  = dying[0];
  assign p2_dying  = dying[1];
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule
